// File: rtl/vec_dtim_responder.sv
// ---------------------------------------------------------------------------
// vec_dtim_responder
//   Memory-side responder for unit-stride vector load/store beats. Owns a
//   single-port DTIM of DEPTH words, each VLEN*32 bits wide. It handles one
//   transaction at a time: IDLE -> ACCESS -> RESP -> IDLE.
//
//   Optional build macro: VEC_DTIM_ERR_CHECK_EN
//     defined   : misaligned, below-base and out-of-range requests are
//                 rejected. No array access is made, and the response has
//                 error=1 and rdata=0.
//     undefined : low address bits are ignored, the index wraps modulo DEPTH,
//                 and error is tied to 0.
//
//   Ports:
//     clock, reset (async, active-low)
//     req_valid/req_ready                 request handshake
//     req_bits_addr/is_store/wdata/wmask  request payload
//     resp_valid/resp_ready               response handshake
//     resp_bits_rdata/resp_bits_error     response payload (held in RESP)
// ---------------------------------------------------------------------------

// One 32-bit lane slice of the array. Each lane has its own storage and byte
// enables, so a partial store touches only the bytes selected by the mask.
module vec_dtim_lane #(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clock,
   input  logic          we,
   input  logic [3:0]    be,
   input  logic [AW-1:0] idx,
   input  logic [31:0]   wd,
   output logic [31:0]   rd
);
   logic [31:0] mem [DEPTH];

   // The array is deliberately not reset; its contents survive reset.
   always_ff @(posedge clock) begin
      if (we) begin
         for (int b = 0; b < 4; b++) begin
            if (be[b]) mem[idx][8*b +: 8] <= wd[8*b +: 8];
         end
      end
   end

   assign rd = mem[idx];
endmodule

module vec_dtim_responder #(
   parameter int          VLEN      = 4,
   parameter int          DEPTH     = 4096,
   parameter logic [31:0] BASE_ADDR = 32'h0800_0000
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [31:0]          req_bits_addr,
   input  logic                 req_bits_is_store,
   input  logic [VLEN*32-1:0]   req_bits_wdata,
   input  logic [VLEN*4-1:0]    req_bits_wmask,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic [VLEN*32-1:0]   resp_bits_rdata,
   output logic                 resp_bits_error
);
   localparam int DW  = VLEN * 32;
   localparam int BW  = VLEN * 4;
   localparam int OFF = $clog2(BW);
   localparam int AW  = $clog2(DEPTH);

   typedef struct packed {
      logic [31:0]   addr;
      logic          is_store;
      logic [DW-1:0] wdata;
      logic [BW-1:0] wmask;
   } req_t;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

   state_t                  state, state_nxt;
   req_t                    req_q;
   logic [DW-1:0]           rdata_q;
   logic                    err_q;
   logic                    lat_en, acc_en, mem_we;
   logic [31:0]             off;
   logic [AW-1:0]           idx;
   logic                    err_w;
   logic [VLEN-1:0][31:0]   rd_lane;

   // Decode the latched address. The subtraction wraps when addr < BASE_ADDR;
   // in the unchecked build that simply becomes part of the modulo-DEPTH wrap.
   assign off = req_q.addr - BASE_ADDR;
   assign idx = AW'(off >> OFF);

`ifdef VEC_DTIM_ERR_CHECK_EN
   assign err_w = (off[OFF-1:0] != '0) ||
                  (req_q.addr < BASE_ADDR) ||
                  ((off >> OFF) >= 32'(DEPTH));
`else
   assign err_w = 1'b0;
`endif

   // ---------------- FSM ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      lat_en     = 1'b0;
      acc_en     = 1'b0;
      mem_we     = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               lat_en    = 1'b1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            acc_en    = 1'b1;
            mem_we    = req_q.is_store && !err_w;
            state_nxt = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // ---------------- request / response registers ----------------
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         req_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (lat_en) begin
            req_q.addr     <= req_bits_addr;
            req_q.is_store <= req_bits_is_store;
            req_q.wdata    <= req_bits_wdata;
            req_q.wmask    <= req_bits_wmask;
         end
         // Stores and rejected requests return zero data.
         if (acc_en) begin
            err_q   <= err_w;
            rdata_q <= (req_q.is_store || err_w) ? '0 : DW'(rd_lane);
         end
      end
   end

   // ---------------- array, one slice per 32-bit lane ----------------
   for (genvar l = 0; l < VLEN; l++) begin : g_lane
      vec_dtim_lane #(.DEPTH(DEPTH), .AW(AW)) u_lane (
         .clock (clock),
         .we    (mem_we),
         .be    (req_q.wmask[4*l +: 4]),
         .idx   (idx),
         .wd    (req_q.wdata[32*l +: 32]),
         .rd    (rd_lane[l])
      );
   end

   assign resp_bits_rdata = rdata_q;
   assign resp_bits_error = err_q;
endmodule
